rot_log_writer: RTL and testbench
=================================

Name: rot_log_writer

Overview:
- Write-side sequencer feeding the rotation-stage RAM block.
- Accepts a 32-bit sample stream over a valid/ready handshake and assigns sequential write addresses.
- Drives the RAM's write address, write strobe, data bus and reference-write strobe.
- Interleaves 16-bit reference-value updates on the shared data bus, so the RAM never sees a sample write and a reference write in the same cycle.

Parameters:
ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W words
DATA_W, 32, sample / RAM data width
REF_W, 16, reference width; carried on data_i[REF_W-1:0]
WRAP, 0, 0 = stop when full; 1 = circular overwrite with sticky overflow

Ports:
clk  in  1  system clock; all logic on posedge; RAM samples outputs on the following negedge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: clear pointer/count/flags, enter LOG
stop  in  1  pulse: return to IDLE
sample_valid  in  1  sample present
sample_data  in  DATA_W  sample word
sample_ready  out  1  writer accepts sample this cycle
ref_req  in  1  pulse: request reference write
ref_value  in  REF_W  reference value, captured with ref_req
address_w  out  ADDR_W  RAM write address
w  out  1  RAM sample-write strobe, one cycle per write
w_ref  out  1  RAM reference-write strobe, one cycle
data_i  out  DATA_W  RAM write data
count  out  ADDR_W+1  words written since start, saturates at DEPTH
full  out  1  WRAP=0: all DEPTH words written
overflow  out  1  WRAP=1: sticky, set on first overwrite of address 0

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; ptr 0; ref_pend 0; ref_buf 0.
- All outputs are registered. Strobes and data are valid for the whole cycle after the posedge that set them, so they are stable at the RAM's negedge.
- States: IDLE, LOG, FULL.
  - IDLE: sample_ready=0; start -> LOG.
  - LOG: sample_ready = ~ref_pend.
  - FULL: sample_ready=0; only start or stop leave it.
- Sample accept: sample_valid & sample_ready at posedge k. The next cycle (k+1) shows w=1, address_w=ptr, data_i=sample_data.
  - ptr increments by 1, modulo DEPTH.
  - count increments, saturating at DEPTH.
  - w is 0 in any cycle without an accept. Back-to-back accepts give continuous w.
- End of memory:
  - WRAP=0: the accept that writes address DEPTH-1 moves the state to FULL and sets full=1 in the same cycle as that write's w.
  - WRAP=1: ptr wraps to 0 and the state stays LOG. The first accept after count==DEPTH sets overflow=1.
- Reference path:
  - ref_req in any state sets ref_pend=1 and ref_buf=ref_value.
  - A ref_req arriving while ref_pend=1 overwrites ref_buf (last wins); only one write is issued.
- Reference issue: at a posedge with ref_pend=1 and no sample accepted, the next cycle shows w_ref=1, data_i = {zeros, ref_buf}, w=0, and ref_pend clears.
- sample_ready depends only on registered ref_pend. Consequences:
  - ref_req in the same cycle as an accept: the sample write goes first, the ref write follows one cycle later.
  - Reference latency is 2 cycles from ref_req to w_ref when the bus is idle.
- w and w_ref are never both 1.
- start in any state:
  - ptr=0, count=0, full=0, overflow=0; state LOG.
  - A sample presented in the same cycle as start is not accepted.
  - ref_pend is preserved.
- stop: state IDLE. count, full, overflow and address_w are held; a pending ref is still issued. start and stop together: start wins.
- rst_n asserted mid-write: w and w_ref drop immediately (asynchronously). The partial sequence is discarded.

Decomposition:
- Shared package (rot_pkg): ADDR_W, DATA_W, REF_W defaults; state encoding constants ST_IDLE=2'd0, ST_LOG=2'd1, ST_FULL=2'd2.
- One sub-module is natural: rot_log_addr_ctr, holding ptr, count saturation, and the wrap/full/overflow logic, with inputs inc, clr and wrap_en.
- FSM, reference buffer and output registers stay in the top module.

Test Plan:
- Reset then start, 3 samples back-to-back (0xA0..0xA2) -> w high for 3 cycles with address_w 0,1,2 and data_i matching; count=3.
- WRAP=0, 256 continuous samples, then valid held high -> last write to address 0xFF, full=1 with it, sample_ready=0, no further w; count=256.
- WRAP=1, 258 samples -> addresses 0..255,0,1; overflow=1 from the write of the 257th sample; count stays 256.
- ref_req(0x1234) while idle bus in LOG -> w_ref=1 two cycles later with data_i=0x00001234, w=0; ref_req in the same cycle as a sample accept -> sample write first, w_ref the next cycle; two ref_req (0x1111, then 0x2222) before issue -> a single w_ref with 0x2222.
- rst_n low during a burst with w=1 -> w, w_ref and all outputs go 0 immediately; after release the block is in IDLE with sample_ready=0.
- stop mid-stream, then start -> sample_ready 0 while in IDLE; after start, address_w restarts at 0 and count=0.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared defaults and state encoding for the rotation-stage write sequencer.
package rot_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int REF_W  = 16;

  // state | meaning
  // IDLE  | not logging; samples refused, pending reference still drains
  // LOG   | accepting samples at sequential addresses
  // FULL  | memory filled (non-wrapping mode); waits for start or stop
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOG  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

endpackage

// File: rtl/rot_log_addr_ctr.sv
// Write pointer, saturating word count and end-of-memory flags.
module rot_log_addr_ctr #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  input  logic              wrap_en,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  output logic              at_last
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  assign at_last = (ptr == {ADDR_W{1'b1}});

  // Pointer advances modulo DEPTH; count saturates; flags are sticky until clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else if (clr) begin
      ptr      <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
      if (count != DEPTH) count <= count + 1'b1;
      if (!wrap_en && at_last) full <= 1'b1;
      if (wrap_en && count == DEPTH) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/rot_log_writer.sv
// Write-side sequencer for the rotation-stage RAM: sample logging with
// interleaved reference writes on the shared data bus.
module rot_log_writer #(
  parameter int ADDR_W = rot_pkg::ADDR_W,
  parameter int DATA_W = rot_pkg::DATA_W,
  parameter int REF_W  = rot_pkg::REF_W,
  parameter int WRAP   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              sample_ready,
  input  logic              ref_req,
  input  logic [REF_W-1:0]  ref_value,
  output logic [ADDR_W-1:0] address_w,
  output logic              w,
  output logic              w_ref,
  output logic [DATA_W-1:0] data_i,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow
);

  import rot_pkg::*;

  localparam logic WRAP_EN = (WRAP != 0);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic              ref_pend;
  logic              ref_pend_nx;
  logic [REF_W-1:0]  ref_buf;
  logic              acc;
  logic              iss;
  logic [ADDR_W-1:0] ptr;
  logic              at_last;

  // A sample offered alongside start is refused so the new run begins clean.
  assign acc = sample_valid & sample_ready & ~start;
  // Samples take priority on the bus; a pending reference goes out on any idle slot.
  assign iss = ref_pend & ~acc;

  rot_log_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (acc),
    .clr      (start),
    .wrap_en  (WRAP_EN),
    .ptr      (ptr),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .at_last  (at_last)
  );

  // A request landing on the issue edge merges into that write (last value wins).
  always_comb begin
    ref_pend_nx = ref_pend;
    if (iss)          ref_pend_nx = 1'b0;
    else if (ref_req) ref_pend_nx = 1'b1;
  end

  // Next state: start beats stop; non-wrapping runs park in FULL after the last address.
  always_comb begin
    state_nx = state;
    if (start)     state_nx = ST_LOG;
    else if (stop) state_nx = ST_IDLE;
    else if (state == ST_LOG && acc && at_last && !WRAP_EN) state_nx = ST_FULL;
  end

  // State, reference buffer and registered RAM-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ref_pend     <= 1'b0;
      ref_buf      <= '0;
      sample_ready <= 1'b0;
      w            <= 1'b0;
      w_ref        <= 1'b0;
      address_w    <= '0;
      data_i       <= '0;
    end else begin
      state        <= state_nx;
      ref_pend     <= ref_pend_nx;
      sample_ready <= (state_nx == ST_LOG) & ~ref_pend_nx;
      w            <= acc;
      w_ref        <= iss;
      if (ref_req) ref_buf <= ref_value;
      if (acc) begin
        address_w <= ptr;
        data_i    <= sample_data;
      end else if (iss) begin
        data_i <= {{(DATA_W-REF_W){1'b0}}, (ref_req ? ref_value : ref_buf)};
      end
    end
  end

endmodule

// File: tb/tb_rot_log_writer.sv
// Self-checking bench: one non-wrapping and one wrapping instance share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_rot_log_writer;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, sample_valid, ref_req;
  logic [31:0] sample_data;
  logic [15:0] ref_value;

  logic        rdy[2];
  logic [7:0]  addr[2];
  logic        w[2], wref[2];
  logic [31:0] dat[2];
  logic [8:0]  cnt[2];
  logic        fl[2], ov[2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rot_log_writer #(.WRAP(0)) u_wrap0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(rdy[0]),
    .ref_req(ref_req), .ref_value(ref_value), .address_w(addr[0]), .w(w[0]),
    .w_ref(wref[0]), .data_i(dat[0]), .count(cnt[0]), .full(fl[0]), .overflow(ov[0]));

  rot_log_writer #(.WRAP(1)) u_wrap1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(rdy[1]),
    .ref_req(ref_req), .ref_value(ref_value), .address_w(addr[1]), .w(w[1]),
    .w_ref(wref[1]), .data_i(dat[1]), .count(cnt[1]), .full(fl[1]), .overflow(ov[1]));

  // Reference model: mode 0 idle, 1 logging, 2 full; m_total = accepts since start.
  int          m_mode[2], m_total[2];
  bit          m_pend[2], m_rdy[2], m_w[2], m_wref[2];
  logic [15:0] m_buf[2];
  logic [7:0]  m_addr[2];
  logic [31:0] m_data[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_total[i] = 0; m_pend[i] = 0; m_rdy[i] = 0;
      m_w[i] = 0; m_wref[i] = 0; m_buf[i] = '0; m_addr[i] = '0; m_data[i] = '0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit acc, iss;
      acc = sample_valid && m_rdy[i] && !start;
      iss = m_pend[i] && !acc;
      m_w[i] = acc;
      m_wref[i] = iss;
      if (acc) begin
        m_addr[i] = 8'(m_total[i] % 256);
        m_data[i] = sample_data;
        m_total[i]++;
      end else if (iss) begin
        m_data[i] = {16'h0, (ref_req ? ref_value : m_buf[i])};
      end
      if (ref_req) m_buf[i] = ref_value;
      if (iss) m_pend[i] = 0;
      else if (ref_req) m_pend[i] = 1;
      if (start) begin
        m_total[i] = 0;
        m_mode[i] = 1;
      end else if (stop) begin
        m_mode[i] = 0;
      end else if (acc && i == 0 && m_total[i] == 256) begin
        m_mode[i] = 2;
      end
      m_rdy[i] = (m_mode[i] == 1) && !m_pend[i];
    end
  endtask

  function automatic logic [53:0] exp_vec(int i);
    logic [8:0] c;
    logic f, o;
    c = (m_total[i] > 256) ? 9'd256 : 9'(m_total[i]);
    f = (i == 0) && (m_total[i] >= 256);
    o = (i == 1) && (m_total[i] > 256);
    return {m_rdy[i], m_addr[i], m_w[i], m_wref[i], m_data[i], c, f, o};
  endfunction

  function automatic logic [53:0] act_vec(int i);
    return {rdy[i], addr[i], w[i], wref[i], dat[i], cnt[i], fl[i], ov[i]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; sample_valid = 0; ref_req = 0;
    sample_data = '0; ref_value = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #12;
    rst_n = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_assert++;
      if (act_vec(i) !== 54'h0) begin
        n_fail++;
        $display("FAIL reset inst%0d: got %h want 0", i, act_vec(i));
      end
    end
  endtask

  task automatic test_basic();
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 4; k++) begin
      sample_valid = (k < 3);
      sample_data = 32'hA0 + 32'(k);
      cyc();
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL basic inst%0d step%0d: got %h want %h", i, k, act_vec(i), exp_vec(i));
        end
      end
      if (k < 3) begin
        n_assert++;
        if (w[0] !== 1'b1 || addr[0] !== 8'(k) || dat[0] !== 32'hA0 + 32'(k)) begin
          n_fail++;
          $display("FAIL basic_write%0d: got w=%b a=%h d=%h want w=1 a=%h d=%h",
                   k, w[0], addr[0], dat[0], k, 32'hA0 + k);
        end
      end
    end
    n_assert++;
    if (cnt[0] !== 9'd3 || w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_count: got cnt=%0d w=%b want cnt=3 w=0", cnt[0], w[0]);
    end
    idle_inputs();
  endtask

  task automatic test_fill();
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 260; k++) begin
      sample_valid = (k < 258);
      sample_data = $urandom;
      cyc();
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL fill inst%0d step%0d: got %h want %h", i, k, act_vec(i), exp_vec(i));
        end
      end
      if (k == 255) begin
        n_assert++;
        if (w[0] !== 1'b1 || addr[0] !== 8'hFF || fl[0] !== 1'b1 || rdy[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_last: got w=%b a=%h full=%b rdy=%b want 1 ff 1 0",
                   w[0], addr[0], fl[0], rdy[0]);
        end
      end
      if (k == 256) begin
        n_assert++;
        if (w[0] !== 1'b0 || w[1] !== 1'b1 || addr[1] !== 8'h00 || ov[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL fill_wrap: got w0=%b w1=%b a1=%h ovf=%b want 0 1 00 1",
                   w[0], w[1], addr[1], ov[1]);
        end
      end
    end
    n_assert++;
    if (cnt[0] !== 9'd256 || cnt[1] !== 9'd256 || addr[1] !== 8'h01 || ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_end: got c0=%0d c1=%0d a1=%h ov0=%b want 256 256 01 0",
               cnt[0], cnt[1], addr[1], ov[0]);
    end
    idle_inputs();
  endtask

  task automatic test_ref();
    start = 1; cyc(); start = 0;
    cyc();
    ref_req = 1; ref_value = 16'h1234; cyc(); ref_req = 0;
    n_assert++;
    if (wref[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ref_wait: got wref=%b rdy=%b want 0 0", wref[0], rdy[0]);
    end
    cyc();
    for (int i = 0; i < 2; i++) begin
      n_assert++;
      if (wref[i] !== 1'b1 || w[i] !== 1'b0 || dat[i] !== 32'h0000_1234) begin
        n_fail++;
        $display("FAIL ref_issue inst%0d: got wref=%b w=%b d=%h want 1 0 00001234",
                 i, wref[i], w[i], dat[i]);
      end
    end
    cyc();
    sample_valid = 1; sample_data = 32'hBEEF_0001; ref_req = 1; ref_value = 16'h5555;
    cyc();
    ref_req = 0;
    n_assert++;
    if (w[0] !== 1'b1 || wref[0] !== 1'b0 || dat[0] !== 32'hBEEF_0001) begin
      n_fail++;
      $display("FAIL ref_same_sample: got w=%b wref=%b d=%h want 1 0 beef0001", w[0], wref[0], dat[0]);
    end
    cyc();
    sample_valid = 0;
    n_assert++;
    if (w[0] !== 1'b0 || wref[0] !== 1'b1 || dat[0] !== 32'h0000_5555) begin
      n_fail++;
      $display("FAIL ref_same_ref: got w=%b wref=%b d=%h want 0 1 00005555", w[0], wref[0], dat[0]);
    end
    cyc();
    ref_req = 1; ref_value = 16'h1111; cyc();
    ref_req = 1; ref_value = 16'h2222; cyc();
    ref_req = 0;
    n_assert++;
    if (wref[0] !== 1'b1 || dat[0] !== 32'h0000_2222) begin
      n_fail++;
      $display("FAIL ref_last_wins: got wref=%b d=%h want 1 00002222", wref[0], dat[0]);
    end
    cyc();
    for (int i = 0; i < 2; i++) begin
      n_assert++;
      if (wref[i] !== 1'b0 || act_vec(i) !== exp_vec(i)) begin
        n_fail++;
        $display("FAIL ref_single inst%0d: got wref=%b vec=%h want 0 %h", i, wref[i], act_vec(i), exp_vec(i));
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    start = 1; cyc(); start = 0;
    sample_valid = 1;
    for (int k = 0; k < 3; k++) begin
      sample_data = $urandom;
      cyc();
    end
    n_assert++;
    if (w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: got w=%b want 1", w[0]);
    end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      n_assert++;
      if (act_vec(i) !== 54'h0) begin
        n_fail++;
        $display("FAIL arst_drop inst%0d: got %h want 0", i, act_vec(i));
      end
    end
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (act_vec(i) !== exp_vec(i) || rdy[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL arst_idle inst%0d step%0d: got %h want %h", i, k, act_vec(i), exp_vec(i));
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_stop_restart();
    start = 1; cyc(); start = 0;
    sample_valid = 1;
    for (int k = 0; k < 6; k++) begin
      sample_data = $urandom;
      stop = (k == 5);
      cyc();
    end
    stop = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_assert++;
      if (rdy[0] !== 1'b0 || w[0] !== 1'b0 || act_vec(0) !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL stop_idle step%0d: got %h want %h", k, act_vec(0), exp_vec(0));
      end
    end
    n_assert++;
    if (cnt[0] !== 9'd6) begin
      n_fail++;
      $display("FAIL stop_hold: got cnt=%0d want 6", cnt[0]);
    end
    start = 1; sample_data = 32'hCAFE_0000; cyc(); start = 0;
    n_assert++;
    if (cnt[0] !== 9'd0 || w[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clr: got cnt=%0d w=%b rdy=%b want 0 0 1", cnt[0], w[0], rdy[0]);
    end
    sample_data = 32'hCAFE_0001; cyc();
    for (int i = 0; i < 2; i++) begin
      n_assert++;
      if (w[i] !== 1'b1 || addr[i] !== 8'h00 || act_vec(i) !== exp_vec(i)) begin
        n_fail++;
        $display("FAIL restart_addr inst%0d: got %h want %h", i, act_vec(i), exp_vec(i));
      end
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_random();
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 700; k++) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      sample_data  = $urandom;
      ref_req      = ($urandom_range(0, 7) == 0);
      ref_value    = 16'($urandom);
      stop         = ($urandom_range(0, 79) == 0);
      start        = ($urandom_range(0, 99) == 0);
      cyc();
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (act_vec(i) !== exp_vec(i) || (w[i] && wref[i])) begin
          n_fail++;
          $display("FAIL random inst%0d step%0d: got %h want %h", i, k, act_vec(i), exp_vec(i));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_ref();
    test_async_reset();
    test_stop_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
